reg_bus_arbiter: RTL and testbench
==================================

Name: reg_bus_arbiter

Overview:
Round-robin arbiter that shares the single-master register access bus (address / write_enable / write_data / read_enable / read_data) of the controlling register bank between NUM_MASTERS requesters. Each requester issues one read or write command through a valid/ready handshake. The arbiter replays the command as a single-cycle strobe on the register bus and returns a one-cycle response pulse (with read data) to the winning requester. It sits between the configuration masters and the register bank that drives the pipe-enable controls.

Parameters:
NUM_MASTERS, 4, number of requesters (2..8)
ADDR_WIDTH, 33, register bus address width
WDATA_WIDTH, 33, register bus write data width
RDATA_WIDTH, 21, register bus read data width
ID_WIDTH, 2, width of grant_id; must be at least clog2(NUM_MASTERS)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  NUM_MASTERS  per-requester command valid
req_write  input  NUM_MASTERS  per-requester direction: 1 = write, 0 = read
req_address  input  NUM_MASTERS*ADDR_WIDTH  packed addresses; requester i occupies slice i
req_wdata  input  NUM_MASTERS*WDATA_WIDTH  packed write data; requester i occupies slice i
req_ready  output  NUM_MASTERS  command accepted; one-hot or zero
rsp_valid  output  NUM_MASTERS  one-cycle completion pulse; one-hot or zero
rsp_rdata  output  RDATA_WIDTH  read data, qualified by rsp_valid
bus_address  output  ADDR_WIDTH  register bus address
bus_write_enable  output  1  register bus write strobe
bus_write_data  output  WDATA_WIDTH  register bus write data
bus_read_enable  output  1  register bus read strobe
bus_read_data  input  RDATA_WIDTH  register bus read data, combinational from the bank
busy  output  1  high whenever the FSM is not in IDLE
grant_id  output  ID_WIDTH  index of the current or last winner

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE; rr_ptr = 0; grant_id = 0.
  - All of req_ready, rsp_valid, rsp_rdata, bus_* outputs and busy = 0.
  - Any latched command is discarded; no response is ever issued for it.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Each non-IDLE state lasts exactly one cycle.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... modulo NUM_MASTERS.
  - req_ready[winner] = 1, combinational from state, rr_ptr and req_valid. All other req_ready bits = 0.
  - On that clock edge: latch the winner's write, address and wdata; grant_id <= winner; go to ACCESS.
  - If no req_valid is high, remain in IDLE.
- ACCESS:
  - bus_address and bus_write_data are driven from the latched command.
  - Exactly one of bus_write_enable / bus_read_enable is high, for one cycle only.
  - For a read, bus_read_data is sampled into rsp_rdata at the end of the cycle.
  - Go to RESP.
- RESP:
  - rsp_valid[grant_id] = 1; rsp_rdata holds the captured read data, or 0 for a write.
  - On exit: rr_ptr <= (grant_id + 1) mod NUM_MASTERS; go to IDLE.
- Outside ACCESS, bus_address, bus_write_data and both strobes are 0.
- Outside RESP, rsp_valid = 0 and rsp_rdata = 0.
- Latency: if the handshake completes at edge T, the strobe is high in cycle T+1 and rsp_valid is high in cycle T+2. Peak throughput is one command per 3 cycles.
- Requester rules:
  - Hold req_valid, address and data stable until req_ready is seen.
  - Dropping req_valid before req_ready means no transaction occurs.
  - A requester may present its next command immediately after its rsp_valid.
- Requests arriving while busy wait; req_ready stays 0 outside IDLE.
- Fairness: a continuously requesting master waits at most NUM_MASTERS-1 grants.
- bus_write_enable and bus_read_enable are never high in the same cycle.

Test Plan:
- Single write: master 2 writes addr 0xAA, data 0x1234 -> req_ready[2] in cycle 0; bus_write_enable=1, bus_address=0xAA, bus_write_data=0x1234 in cycle 1; rsp_valid=4'b0100 with rsp_rdata=0 in cycle 2.
- Single read: master 0 reads addr 0x55 with bus_read_data=0x00001 -> bus_read_enable for one cycle; rsp_valid[0] with rsp_rdata=0x00001 one cycle later.
- Contention: all 4 masters request from reset -> grant order 0,1,2,3,0; req_ready pulses spaced exactly 3 cycles apart; strobes never overlap.
- Pointer wrap: after master 3 is served, masters 1 and 3 request -> master 1 wins (rr_ptr = 0, first valid found is 1).
- Withdrawn request: master 1 raises req_valid while busy, drops it before IDLE -> no req_ready[1], no bus strobe, no rsp_valid[1].
- Reset mid-operation: assert reset during ACCESS -> strobe drops immediately; after release, no rsp_valid; next request is granted from rr_ptr = 0.

Source files
------------

// File: rtl/reg_bus_arbiter_if.sv
// Requester handshake and register-bus signals shared by the arbiter, its
// configuration masters and the register bank.
interface reg_bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ADDR_WIDTH  = 33,
  parameter int unsigned WDATA_WIDTH = 33,
  parameter int unsigned RDATA_WIDTH = 21
);
  logic [NUM_MASTERS-1:0]             req_valid;
  logic [NUM_MASTERS-1:0]             req_write;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  req_address;
  logic [NUM_MASTERS*WDATA_WIDTH-1:0] req_wdata;
  logic [NUM_MASTERS-1:0]             req_ready;
  logic [NUM_MASTERS-1:0]             rsp_valid;
  logic [RDATA_WIDTH-1:0]             rsp_rdata;
  logic [ADDR_WIDTH-1:0]              bus_address;
  logic                               bus_write_enable;
  logic [WDATA_WIDTH-1:0]             bus_write_data;
  logic                               bus_read_enable;
  logic [RDATA_WIDTH-1:0]             bus_read_data;

  // Requesters plus register bank: everything the arbiter consumes.
  modport master (
    output req_valid, req_write, req_address, req_wdata, bus_read_data,
    input  req_ready, rsp_valid, rsp_rdata,
    input  bus_address, bus_write_enable, bus_write_data, bus_read_enable
  );

  // Arbiter view.
  modport slave (
    input  req_valid, req_write, req_address, req_wdata, bus_read_data,
    output req_ready, rsp_valid, rsp_rdata,
    output bus_address, bus_write_enable, bus_write_data, bus_read_enable
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter replaying one requester command at a time as a
// single-cycle strobe on the register bus, then pulsing the response back.
module reg_bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ADDR_WIDTH  = 33,
  parameter int unsigned WDATA_WIDTH = 33,
  parameter int unsigned RDATA_WIDTH = 21,
  parameter int unsigned ID_WIDTH    = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  reg_bus_arbiter_if.slave     bus_if,
  output logic                 busy,
  output logic [ID_WIDTH-1:0]  grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] winner;
  logic [ID_WIDTH-1:0] cand;
  logic                found;
  int unsigned         idx;

  // First valid requester at or after rr_ptr, only offered while idle.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      idx  = (32'(rr_ptr) + k) % NUM_MASTERS;
      cand = ID_WIDTH'(idx);
      if (!found && state == IDLE && bus_if.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    bus_if.req_ready = '0;
    if (found) bus_if.req_ready[winner] = 1'b1;
  end

  // Bus strobes live only in ACCESS; a read is told apart by the read strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                   <= IDLE;
      rr_ptr                  <= '0;
      grant_id                <= '0;
      busy                    <= 1'b0;
      bus_if.bus_address      <= '0;
      bus_if.bus_write_data   <= '0;
      bus_if.bus_write_enable <= 1'b0;
      bus_if.bus_read_enable  <= 1'b0;
      bus_if.rsp_valid        <= '0;
      bus_if.rsp_rdata        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id                <= winner;
            busy                    <= 1'b1;
            bus_if.bus_address      <= bus_if.req_address[winner*ADDR_WIDTH +: ADDR_WIDTH];
            bus_if.bus_write_data   <= bus_if.req_wdata[winner*WDATA_WIDTH +: WDATA_WIDTH];
            bus_if.bus_write_enable <= bus_if.req_write[winner];
            bus_if.bus_read_enable  <= !bus_if.req_write[winner];
            state                   <= ACCESS;
          end
        end
        ACCESS: begin
          bus_if.bus_address      <= '0;
          bus_if.bus_write_data   <= '0;
          bus_if.bus_write_enable <= 1'b0;
          bus_if.bus_read_enable  <= 1'b0;
          bus_if.rsp_valid        <= NUM_MASTERS'(1) << grant_id;
          bus_if.rsp_rdata        <= bus_if.bus_read_enable ? bus_if.bus_read_data : '0;
          state                   <= RESP;
        end
        RESP: begin
          bus_if.rsp_valid <= '0;
          bus_if.rsp_rdata <= '0;
          busy             <= 1'b0;
          rr_ptr           <= ID_WIDTH'((32'(grant_id) + 1) % NUM_MASTERS);
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: single accesses, contention ordering,
// pointer wrap, withdrawn request and reset during an access.
module tb_reg_bus_arbiter;
  localparam int unsigned NM = 4;
  localparam int unsigned AW = 33;
  localparam int unsigned WW = 33;
  localparam int unsigned RW = 21;
  localparam int unsigned IW = 2;

  logic          clock;
  logic          reset;
  logic          busy;
  logic [IW-1:0] grant_id;
  int            checks;
  int            failures;

  reg_bus_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .WDATA_WIDTH(WW), .RDATA_WIDTH(RW)) bus_if ();

  reg_bus_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .WDATA_WIDTH(WW), .RDATA_WIDTH(RW), .ID_WIDTH(IW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus_if   (bus_if),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int m, input logic wr, input logic [AW-1:0] a, input logic [WW-1:0] d);
    bus_if.req_valid[m]          = 1'b1;
    bus_if.req_write[m]          = wr;
    bus_if.req_address[m*AW +: AW] = a;
    bus_if.req_wdata[m*WW +: WW]   = d;
  endtask

  task automatic clr_req(input int m);
    bus_if.req_valid[m] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  int          order [5] = '{0, 1, 2, 3, 0};
  logic [63:0] exp_v;

  initial begin
    checks             = 0;
    failures           = 0;
    clock              = 1'b0;
    reset              = 1'b0;
    bus_if.req_valid   = '0;
    bus_if.req_write   = '0;
    bus_if.req_address = '0;
    bus_if.req_wdata   = '0;
    bus_if.bus_read_data = '0;

    #1;
    check("rst_ready", 64'(bus_if.req_ready), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_grant", 64'(grant_id), 0);
    check("rst_we", 64'(bus_if.bus_write_enable), 0);
    check("rst_re", 64'(bus_if.bus_read_enable), 0);
    check("rst_rsp", 64'(bus_if.rsp_valid), 0);
    do_reset();

    // single write from master 2
    set_req(2, 1'b1, 33'hAA, 33'h1234);
    #1 check("wr_ready", 64'(bus_if.req_ready), 64'b0100);
    step();
    clr_req(2);
    check("wr_we", 64'(bus_if.bus_write_enable), 1);
    check("wr_re", 64'(bus_if.bus_read_enable), 0);
    check("wr_addr", 64'(bus_if.bus_address), 64'hAA);
    check("wr_data", 64'(bus_if.bus_write_data), 64'h1234);
    check("wr_grant", 64'(grant_id), 2);
    check("wr_busy", 64'(busy), 1);
    check("wr_ready_busy", 64'(bus_if.req_ready), 0);
    step();
    check("wr_rsp", 64'(bus_if.rsp_valid), 64'b0100);
    check("wr_rdata", 64'(bus_if.rsp_rdata), 0);
    check("wr_we_off", 64'(bus_if.bus_write_enable), 0);
    check("wr_addr_off", 64'(bus_if.bus_address), 0);
    step();
    check("wr_rsp_off", 64'(bus_if.rsp_valid), 0);
    check("wr_idle", 64'(busy), 0);

    // single read from master 0
    bus_if.bus_read_data = 21'h00001;
    set_req(0, 1'b0, 33'h55, 33'h0);
    #1 check("rd_ready", 64'(bus_if.req_ready), 64'b0001);
    step();
    clr_req(0);
    check("rd_re", 64'(bus_if.bus_read_enable), 1);
    check("rd_we", 64'(bus_if.bus_write_enable), 0);
    check("rd_addr", 64'(bus_if.bus_address), 64'h55);
    step();
    check("rd_rsp", 64'(bus_if.rsp_valid), 64'b0001);
    check("rd_rdata", 64'(bus_if.rsp_rdata), 64'h1);
    check("rd_re_off", 64'(bus_if.bus_read_enable), 0);
    step();
    check("rd_rdata_off", 64'(bus_if.rsp_rdata), 0);

    // contention from reset: even masters write, odd masters read
    do_reset();
    bus_if.bus_read_data = 21'h1F00F;
    for (int m = 0; m < 4; m++) set_req(m, (m % 2) == 0, AW'(m + 16), WW'(m + 256));
    #1;
    for (int g = 0; g < 5; g++) begin
      exp_v = 64'(1) << order[g];
      check($sformatf("ct%0d_ready", g), 64'(bus_if.req_ready), exp_v);
      step();
      check($sformatf("ct%0d_grant", g), 64'(grant_id), 64'(order[g]));
      check($sformatf("ct%0d_we", g), 64'(bus_if.bus_write_enable), 64'((order[g] % 2) == 0));
      check($sformatf("ct%0d_re", g), 64'(bus_if.bus_read_enable), 64'((order[g] % 2) == 1));
      check($sformatf("ct%0d_addr", g), 64'(bus_if.bus_address), 64'(order[g] + 16));
      check($sformatf("ct%0d_gap1", g), 64'(bus_if.req_ready), 0);
      step();
      check($sformatf("ct%0d_rsp", g), 64'(bus_if.rsp_valid), exp_v);
      check($sformatf("ct%0d_rdata", g), 64'(bus_if.rsp_rdata),
            ((order[g] % 2) == 0) ? 64'h0 : 64'h1F00F);
      check($sformatf("ct%0d_gap2", g), 64'(bus_if.req_ready), 0);
      check($sformatf("ct%0d_strobes", g),
            64'(bus_if.bus_write_enable | bus_if.bus_read_enable), 0);
      step();
    end
    bus_if.req_valid = '0;
    step();

    // pointer wrap: serve master 3, then 1 and 3 compete with rr_ptr back at 0
    do_reset();
    set_req(3, 1'b1, 33'h30, 33'h3);
    #1 check("wrap_first", 64'(bus_if.req_ready), 64'b1000);
    step();
    clr_req(3);
    step();
    step();
    set_req(1, 1'b0, 33'h11, 33'h0);
    set_req(3, 1'b1, 33'h33, 33'h33);
    #1 check("wrap_ready", 64'(bus_if.req_ready), 64'b0010);
    step();
    clr_req(1);
    clr_req(3);
    check("wrap_grant", 64'(grant_id), 1);
    check("wrap_addr", 64'(bus_if.bus_address), 64'h11);
    step();
    step();

    // withdrawn request: master 1 asks only while master 2 is being served
    set_req(2, 1'b1, 33'h22, 33'h22);
    #1 check("wd_ready2", 64'(bus_if.req_ready), 64'b0100);
    step();
    clr_req(2);
    set_req(1, 1'b1, 33'h77, 33'h77);
    #1 check("wd_ready_busy", 64'(bus_if.req_ready), 0);
    step();
    check("wd_rsp2", 64'(bus_if.rsp_valid), 64'b0100);
    check("wd_ready_resp", 64'(bus_if.req_ready), 0);
    clr_req(1);
    step();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("wd%0d_ready", c), 64'(bus_if.req_ready), 0);
      check($sformatf("wd%0d_strobe", c),
            64'(bus_if.bus_write_enable | bus_if.bus_read_enable), 0);
      check($sformatf("wd%0d_rsp", c), 64'(bus_if.rsp_valid), 0);
      step();
    end

    // reset during ACCESS: rr_ptr would be 2 without it
    set_req(1, 1'b1, 33'h41, 33'h41);
    #1 check("mr_pre_ready", 64'(bus_if.req_ready), 64'b0010);
    step();
    clr_req(1);
    step();
    step();
    set_req(3, 1'b1, 33'h3C, 33'h3C);
    #1 check("mr_ready3", 64'(bus_if.req_ready), 64'b1000);
    step();
    clr_req(3);
    check("mr_we_on", 64'(bus_if.bus_write_enable), 1);
    reset = 1'b0;
    #1;
    check("mr_we_drop", 64'(bus_if.bus_write_enable), 0);
    check("mr_addr_drop", 64'(bus_if.bus_address), 0);
    check("mr_busy", 64'(busy), 0);
    check("mr_grant", 64'(grant_id), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("mr%0d_rsp", c), 64'(bus_if.rsp_valid), 0);
      step();
    end
    set_req(1, 1'b0, 33'h61, 33'h0);
    set_req(2, 1'b0, 33'h62, 33'h0);
    #1 check("mr_post_ready", 64'(bus_if.req_ready), 64'b0010);
    step();
    clr_req(1);
    clr_req(2);
    check("mr_post_grant", 64'(grant_id), 1);
    step();
    check("mr_post_rsp", 64'(bus_if.rsp_valid), 64'b0010);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
